// File: rtl/mem_bus_pkg.sv
// Shared types and command encodings for the two-master memory bus arbiter.
package mem_bus_pkg;

    typedef logic [1:0] mem_cmd_t;

    localparam mem_cmd_t MREAD  = 2'b11;
    localparam mem_cmd_t MWRITE = 2'b01;
    localparam mem_cmd_t MNONE  = 2'b00;

    typedef enum logic [1:0] {
        ARB,
        ISSUE,
        RDWAIT
    } arb_state_t;

    // Encodings other than read/write (00, 10) reach the bus as an idle command.
    function automatic mem_cmd_t cmd_norm(input mem_cmd_t c);
        return ((c == MREAD) || (c == MWRITE)) ? c : MNONE;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side request/response signals plus the shared RAM/MMIO bus.
interface mem_bus_arbiter_if
    import mem_bus_pkg::*;
#(
    parameter int data_width = 16,
    parameter int addr_width = 9
);
    logic                  m0_req;
    logic                  m0_lock;
    mem_cmd_t              m0_cmd;
    logic [addr_width-1:0] m0_addr;
    logic [data_width-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [data_width-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_lock;
    mem_cmd_t              m1_cmd;
    logic [addr_width-1:0] m1_addr;
    logic [data_width-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [data_width-1:0] m1_rdata;

    mem_cmd_t              mem_cmd;
    logic [addr_width-1:0] mem_addr;
    logic [data_width-1:0] mem_wdata;
    logic [data_width-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_lock, m0_cmd, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_lock, m1_cmd, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_cmd, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_lock, m0_cmd, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_lock, m1_cmd, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_cmd, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb_2.sv
// Two-way round-robin selector with a bounded lock: a locking owner keeps the bus
// until it has MAX_HOLD consecutive grants while the other master is waiting.
module rr_arb_2 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    input  logic       i_take,
    output logic       o_win
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    logic          r_ptr;
    logic          r_owner;
    logic          r_lock;
    logic [HW-1:0] r_hold;

    logic w_other;
    logic w_keep;
    logic w_win;
    logic w_loser;

    always_comb begin
        w_other = ~r_owner;
        w_keep  = r_lock && i_req[r_owner] &&
                  !(i_req[w_other] && (r_hold >= HW'(MAX_HOLD)));
        w_win   = r_ptr;
        if (w_keep)
            w_win = r_owner;
        else if (i_req == 2'b11)
            w_win = r_ptr;
        else
            w_win = i_req[1];
        w_loser = ~w_win;
    end

    assign o_win = w_win;

    // Hold counts only grants made while the other master was waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_lock  <= 1'b0;
            r_hold  <= '0;
        end else if (i_take) begin
            r_ptr   <= w_loser;
            r_owner <= w_win;
            r_lock  <= i_lock[w_win];
            if (!i_req[w_loser])
                r_hold <= '0;
            else if (w_win != r_owner)
                r_hold <= HW'(1);
            else if (r_hold != HW'(MAX_HOLD))
                r_hold <= r_hold + HW'(1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one RAM/MMIO port between two masters: ARB -> ISSUE -> (RDWAIT) sequencing,
// registered bus command/address/data and read-data steering back to the owner.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int data_width = 16,
    parameter int addr_width = 9,
    parameter int RD_LAT     = 1,
    parameter int MAX_HOLD   = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus
);

    localparam int CW = $clog2(RD_LAT + 1);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic                  r_win;
    mem_cmd_t              r_mem_cmd;
    logic [addr_width-1:0] r_mem_addr;
    logic [data_width-1:0] r_mem_wdata;

    logic [1:0]            w_req;
    logic                  w_take;
    logic                  w_win;
    logic                  w_rvalid;
    logic                  w_rv0;
    logic                  w_rv1;
    mem_cmd_t              w_sel_cmd;
    logic [addr_width-1:0] w_sel_addr;
    logic [data_width-1:0] w_sel_wdata;

    assign w_req  = {bus.m1_req, bus.m0_req};
    assign w_take = (r_state == ARB) && (w_req != 2'b00);

    rr_arb_2 #(.MAX_HOLD(MAX_HOLD)) u_arb (
        .clk    (clk),
        .rst_n  (reset),
        .i_req  (w_req),
        .i_lock ({bus.m1_lock, bus.m0_lock}),
        .i_take (w_take),
        .o_win  (w_win)
    );

    always_comb begin
        w_sel_cmd   = bus.m0_cmd;
        w_sel_addr  = bus.m0_addr;
        w_sel_wdata = bus.m0_wdata;
        if (w_win) begin
            w_sel_cmd   = bus.m1_cmd;
            w_sel_addr  = bus.m1_addr;
            w_sel_wdata = bus.m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ARB;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB:     if (w_take) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = (r_mem_cmd == MREAD) ? RDWAIT : ARB;
            RDWAIT:  if (r_cnt == CW'(RD_LAT)) w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    // mem_cmd is live only during ISSUE; address and write data keep their last values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win       <= 1'b0;
            r_mem_cmd   <= MNONE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_take) begin
                        r_win       <= w_win;
                        r_mem_cmd   <= cmd_norm(w_sel_cmd);
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                    end
                end
                ISSUE: begin
                    r_mem_cmd <= MNONE;
                    r_cnt     <= CW'(1);
                end
                RDWAIT:  r_cnt <= r_cnt + CW'(1);
                default: r_cnt <= '0;
            endcase
        end
    end

    assign w_rvalid = (r_state == RDWAIT) && (r_cnt == CW'(RD_LAT));
    assign w_rv0    = w_rvalid && !r_win;
    assign w_rv1    = w_rvalid && r_win;

    assign bus.m0_gnt    = (r_state == ISSUE) && !r_win;
    assign bus.m1_gnt    = (r_state == ISSUE) && r_win;
    assign bus.m0_rvalid = w_rv0;
    assign bus.m1_rvalid = w_rv1;
    assign bus.m0_rdata  = w_rv0 ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = w_rv1 ? bus.mem_rdata : '0;

    assign bus.mem_cmd   = r_mem_cmd;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table for single-master traffic,
// hand sequences for round robin, lock hold limit and reset during a read.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.data_width(16), .addr_width(9)) bus ();

    mem_bus_arbiter #(
        .data_width (16),
        .addr_width (9),
        .RD_LAT     (1),
        .MAX_HOLD   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Simple synchronous RAM, one cycle read latency.
    logic [15:0] ram [0:511];
    logic [15:0] r_rd = 16'h0000;
    assign bus.mem_rdata = r_rd;
    always @(posedge clk) begin
        if (bus.mem_cmd == MWRITE) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_cmd == MREAD)  r_rd <= ram[bus.mem_addr];
    end

    typedef struct {
        logic        r0; logic l0; logic [1:0] c0; logic [8:0] a0; logic [15:0] d0;
        logic        r1; logic l1; logic [1:0] c1; logic [8:0] a1; logic [15:0] d1;
        logic        g0; logic g1; logic v0; logic v1;
        logic [15:0] rd0; logic [15:0] rd1;
        logic [1:0]  cmd; logic [8:0] addr; logic [15:0] wd;
    } vec_t;

    vec_t vecs [0:13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_g0"},    bus.m0_gnt, 0);
        chk({tag, "_g1"},    bus.m1_gnt, 0);
        chk({tag, "_v0"},    bus.m0_rvalid, 0);
        chk({tag, "_v1"},    bus.m1_rvalid, 0);
        chk({tag, "_rd0"},   bus.m0_rdata, 0);
        chk({tag, "_rd1"},   bus.m1_rdata, 0);
        chk({tag, "_cmd"},   bus.mem_cmd, 0);
        chk({tag, "_addr"},  bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
    endtask

    task automatic drive_idle();
        bus.m0_req = 1'b0; bus.m0_lock = 1'b0; bus.m0_cmd = MNONE;
        bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_lock = 1'b0; bus.m1_cmd = MNONE;
        bus.m1_addr = '0; bus.m1_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Waits (bounded) for the next grant; checks exclusivity and read data on the way.
    task automatic wait_gnt(output int who);
        who = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("gnt_both", bus.m0_gnt & bus.m1_gnt, 0);
            chk("rv_both",  bus.m0_rvalid & bus.m1_rvalid, 0);
            chk("gnt_rv0",  bus.m0_gnt & bus.m0_rvalid, 0);
            chk("gnt_rv1",  bus.m1_gnt & bus.m1_rvalid, 0);
            if (bus.m0_rvalid) chk("seq_rd0", bus.m0_rdata, 16'hBEEF);
            if (bus.m1_rvalid) chk("seq_rd1", bus.m1_rdata, 16'h1234);
            if (bus.m0_gnt) begin who = 0; break; end
            if (bus.m1_gnt) begin who = 1; break; end
        end
        if (who < 0) chk("gnt_timeout", 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        int exp3 [4];
        int exp4 [6];
        exp3 = '{0, 1, 0, 1};
        exp4 = '{1, 1, 1, 1, 0, 1};

        //            r0   l0   c0     a0      d0        r1   l1   c1     a1      d1
        //            g0   g1   v0   v1   rd0       rd1       cmd    addr    wd
        vecs[0]  = '{1'b1,1'b0,2'b01,9'h010,16'hBEEF, 1'b0,1'b0,2'b00,9'h000,16'h0000,
                     1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b00,9'h000,16'h0000};
        vecs[1]  = '{1'b1,1'b0,2'b11,9'h010,16'h0000, 1'b0,1'b0,2'b00,9'h000,16'h0000,
                     1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b01,9'h010,16'hBEEF};
        vecs[2]  = '{1'b1,1'b0,2'b11,9'h010,16'h0000, 1'b0,1'b0,2'b00,9'h000,16'h0000,
                     1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b00,9'h010,16'hBEEF};
        vecs[3]  = '{1'b0,1'b0,2'b00,9'h000,16'h0000, 1'b0,1'b0,2'b00,9'h000,16'h0000,
                     1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b11,9'h010,16'h0000};
        vecs[4]  = '{1'b0,1'b0,2'b00,9'h000,16'h0000, 1'b0,1'b0,2'b00,9'h000,16'h0000,
                     1'b0,1'b0,1'b1,1'b0,16'hBEEF,16'h0000,2'b00,9'h010,16'h0000};
        vecs[5]  = '{1'b1,1'b0,2'b00,9'h055,16'h0000, 1'b0,1'b0,2'b00,9'h000,16'h0000,
                     1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b00,9'h010,16'h0000};
        vecs[6]  = '{1'b0,1'b0,2'b00,9'h000,16'h0000, 1'b0,1'b0,2'b00,9'h000,16'h0000,
                     1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b00,9'h055,16'h0000};
        vecs[7]  = '{1'b0,1'b0,2'b00,9'h000,16'h0000, 1'b0,1'b0,2'b00,9'h000,16'h0000,
                     1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b00,9'h055,16'h0000};
        vecs[8]  = '{1'b0,1'b0,2'b00,9'h000,16'h0000, 1'b1,1'b0,2'b01,9'h1A0,16'h1234,
                     1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b00,9'h055,16'h0000};
        vecs[9]  = '{1'b0,1'b0,2'b00,9'h000,16'h0000, 1'b1,1'b0,2'b11,9'h1A0,16'h0000,
                     1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,2'b01,9'h1A0,16'h1234};
        vecs[10] = '{1'b0,1'b0,2'b00,9'h000,16'h0000, 1'b1,1'b0,2'b11,9'h1A0,16'h0000,
                     1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b00,9'h1A0,16'h1234};
        vecs[11] = '{1'b0,1'b0,2'b00,9'h000,16'h0000, 1'b0,1'b0,2'b00,9'h000,16'h0000,
                     1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,2'b11,9'h1A0,16'h0000};
        vecs[12] = '{1'b0,1'b0,2'b00,9'h000,16'h0000, 1'b0,1'b0,2'b00,9'h000,16'h0000,
                     1'b0,1'b0,1'b0,1'b1,16'h0000,16'h1234,2'b00,9'h1A0,16'h0000};
        vecs[13] = '{1'b0,1'b0,2'b00,9'h000,16'h0000, 1'b0,1'b0,2'b00,9'h000,16'h0000,
                     1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b00,9'h1A0,16'h0000};

        for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
        drive_idle();

        repeat (3) @(posedge clk);
        #1 check_zero("in_reset");
        reset = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        // Single-master write, read, NONE command and m1 traffic, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            bus.m0_req = vecs[i].r0; bus.m0_lock = vecs[i].l0; bus.m0_cmd = vecs[i].c0;
            bus.m0_addr = vecs[i].a0; bus.m0_wdata = vecs[i].d0;
            bus.m1_req = vecs[i].r1; bus.m1_lock = vecs[i].l1; bus.m1_cmd = vecs[i].c1;
            bus.m1_addr = vecs[i].a1; bus.m1_wdata = vecs[i].d1;
            @(negedge clk);
            chk($sformatf("v%0d_g0", i),    bus.m0_gnt,    vecs[i].g0);
            chk($sformatf("v%0d_g1", i),    bus.m1_gnt,    vecs[i].g1);
            chk($sformatf("v%0d_v0", i),    bus.m0_rvalid, vecs[i].v0);
            chk($sformatf("v%0d_v1", i),    bus.m1_rvalid, vecs[i].v1);
            chk($sformatf("v%0d_rd0", i),   bus.m0_rdata,  vecs[i].rd0);
            chk($sformatf("v%0d_rd1", i),   bus.m1_rdata,  vecs[i].rd1);
            chk($sformatf("v%0d_cmd", i),   bus.mem_cmd,   vecs[i].cmd);
            chk($sformatf("v%0d_addr", i),  bus.mem_addr,  vecs[i].addr);
            chk($sformatf("v%0d_wdata", i), bus.mem_wdata, vecs[i].wd);
        end

        // Both masters reading continuously, no lock: strict alternation from reset.
        drive_idle();
        do_reset();
        bus.m0_req = 1'b1; bus.m0_cmd = MREAD; bus.m0_addr = 9'h010;
        bus.m1_req = 1'b1; bus.m1_cmd = MREAD; bus.m1_addr = 9'h1A0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(who);
            chk($sformatf("rr_gnt%0d", i), who, exp3[i]);
        end
        drive_idle();
        repeat (4) @(posedge clk);

        // m1 locks: after its lone grant it keeps the bus for MAX_HOLD contested grants.
        do_reset();
        bus.m1_req = 1'b1; bus.m1_lock = 1'b1; bus.m1_cmd = MREAD; bus.m1_addr = 9'h1A0;
        wait_gnt(who);
        chk("lock_first", who, 1);
        bus.m0_req = 1'b1; bus.m0_cmd = MREAD; bus.m0_addr = 9'h010;
        for (int i = 0; i < 6; i++) begin
            wait_gnt(who);
            chk($sformatf("lock_gnt%0d", i), who, exp4[i]);
        end
        drive_idle();
        repeat (4) @(posedge clk);

        // Reset during the read-return cycle; pointer left at m1 beforehand.
        bus.m0_req = 1'b1; bus.m0_cmd = MREAD; bus.m0_addr = 9'h010;
        wait_gnt(who);
        chk("rst_pre_gnt", who, 0);
        bus.m0_req = 1'b0;
        @(posedge clk);
        #1 chk("rst_pre_rv", bus.m0_rvalid, 1);
        reset = 1'b0;
        #1 check_zero("mid_read_rst");
        bus.m0_req = 1'b1; bus.m0_cmd = MREAD; bus.m0_addr = 9'h010;
        bus.m1_req = 1'b1; bus.m1_cmd = MREAD; bus.m1_addr = 9'h1A0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wait_gnt(who);
        chk("rst_tie", who, 0);
        drive_idle();
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
